// File: rtl/bgpu_pkg.sv
// Shared widths, typedefs and PC field helpers for the GPU core front end.
package bgpu_pkg;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  localparam int PcWidth          = 9;
  localparam int NumWarps         = 16;
  localparam int WarpWidth        = 4;
  localparam int EncInstWidth     = 32;
  localparam int CachelineIdxBits = 2;
  localparam int NumCachelines    = 16;

  localparam int WidWidth       = clog2_min1(NumWarps);
  localparam int SubwarpIdWidth = clog2_min1(WarpWidth);
  localparam int LineWords      = 2 ** CachelineIdxBits;
  localparam int LineWidth      = EncInstWidth * LineWords;
  localparam int IdxBits        = $clog2(NumCachelines);
  localparam int TagBits        = PcWidth - CachelineIdxBits - IdxBits;
  localparam int CacheAddrWidth = PcWidth - CachelineIdxBits;

  typedef logic [PcWidth-1:0]          pc_t;
  typedef logic [WarpWidth-1:0]        act_mask_t;
  typedef logic [WidWidth-1:0]         wid_t;
  typedef logic [SubwarpIdWidth-1:0]   subwarp_id_t;
  typedef logic [EncInstWidth-1:0]     enc_inst_t;
  typedef logic [CacheAddrWidth-1:0]   cache_addr_t;
  typedef logic [LineWidth-1:0]        line_t;
  typedef logic [IdxBits-1:0]          idx_t;
  typedef logic [TagBits-1:0]          tag_t;
  typedef logic [CachelineIdxBits-1:0] word_off_t;

  function automatic idx_t pc_idx(input pc_t pc);
    return pc[CachelineIdxBits+IdxBits-1:CachelineIdxBits];
  endfunction

  function automatic tag_t pc_tag(input pc_t pc);
    return pc[PcWidth-1:CachelineIdxBits+IdxBits];
  endfunction

  function automatic word_off_t pc_off(input pc_t pc);
    return pc[CachelineIdxBits-1:0];
  endfunction

  function automatic enc_inst_t line_word(input line_t line, input word_off_t off);
    return line[int'(off)*EncInstWidth +: EncInstWidth];
  endfunction

endpackage

// File: rtl/instr_cache_tag_array.sv
// Valid/tag/data storage of the direct-mapped instruction cache.
// Lookup is a combinational read of the contents before the edge.
module instr_cache_tag_array
  import bgpu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [PcWidth-1:0]        lookup_pc,
  output logic                      hit,
  output logic [EncInstWidth-1:0]   word,
  input  logic                      fill_en,
  input  logic [CacheAddrWidth-1:0] fill_addr,
  input  logic [LineWidth-1:0]      fill_data
);

  logic [NumCachelines-1:0] valid_q;
  tag_t                     tag_q  [NumCachelines];
  line_t                    data_q [NumCachelines];

  idx_t  lk_idx;
  idx_t  fill_idx;
  tag_t  fill_tag;
  line_t rd_line;

  assign lk_idx   = pc_idx(lookup_pc);
  assign fill_idx = fill_addr[IdxBits-1:0];
  assign fill_tag = fill_addr[CacheAddrWidth-1:IdxBits];
  assign rd_line  = data_q[lk_idx];
  assign hit      = valid_q[lk_idx] && (tag_q[lk_idx] == pc_tag(lookup_pc));
  assign word     = line_word(rd_line, pc_off(lookup_pc));

  // Valid bits: flush wins over a same-cycle fill so the line stays invalid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data are written on every fill, flush or not.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/instr_cache.sv
// Blocking direct-mapped instruction cache: one request stage, misses fetch
// a whole line from instruction memory, responses return in accept order.
module instr_cache
  import bgpu_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      mem_ready_i,
  output logic                      mem_req_o,
  output logic [CacheAddrWidth-1:0] mem_addr_o,
  input  logic                      mem_valid_i,
  input  logic [LineWidth-1:0]      mem_data_i,
  output logic                      ic_ready_o,
  input  logic                      fe_valid_i,
  input  logic [PcWidth-1:0]        fe_pc_i,
  input  logic [WarpWidth-1:0]      fe_act_mask_i,
  input  logic [WidWidth-1:0]       fe_warp_id_i,
  input  logic [SubwarpIdWidth-1:0] fe_subwarp_id_i,
  input  logic                      dec_ready_i,
  output logic                      ic_valid_o,
  output logic [PcWidth-1:0]        ic_pc_o,
  output logic [WarpWidth-1:0]      ic_act_mask_o,
  output logic [WidWidth-1:0]       ic_warp_id_o,
  output logic [SubwarpIdWidth-1:0] ic_subwarp_id_o,
  output logic [EncInstWidth-1:0]   ic_inst_o
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RESP      = 2'd1;
  localparam logic [1:0] MISS_REQ  = 2'd2;
  localparam logic [1:0] MISS_WAIT = 2'd3;

  logic [1:0]  state_q;
  pc_t         pc_p1;
  act_mask_t   act_mask_p1;
  wid_t        warp_id_p1;
  subwarp_id_t subwarp_id_p1;
  enc_inst_t   inst_p1;
  cache_addr_t mem_addr_p1;
  logic        vld_p1;

  logic        accept;
  logic        lookup_hit;
  enc_inst_t   lookup_word;
  logic        fill_en;
  enc_inst_t   fill_word;

  assign ic_ready_o = (state_q == IDLE) || ((state_q == RESP) && dec_ready_i);
  assign accept     = fe_valid_i && ic_ready_o;
  assign fill_en    = (state_q == MISS_WAIT) && mem_valid_i;
  assign fill_word  = line_word(mem_data_i, pc_off(pc_p1));
  assign vld_p1     = (state_q == RESP);

  assign ic_valid_o      = vld_p1;
  assign ic_pc_o         = pc_p1;
  assign ic_act_mask_o   = act_mask_p1;
  assign ic_warp_id_o    = warp_id_p1;
  assign ic_subwarp_id_o = subwarp_id_p1;
  assign ic_inst_o       = inst_p1;
  assign mem_req_o       = (state_q == MISS_REQ);
  assign mem_addr_o      = mem_addr_p1;

  instr_cache_tag_array u_tag_array (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .lookup_pc (fe_pc_i),
    .hit       (lookup_hit),
    .word      (lookup_word),
    .fill_en   (fill_en),
    .fill_addr (mem_addr_p1),
    .fill_data (mem_data_i)
  );

  // Stage FSM: accept -> (hit) RESP or (miss) MISS_REQ -> MISS_WAIT -> RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            state_q <= lookup_hit ? RESP : MISS_REQ;
          end else if ((state_q == RESP) && dec_ready_i) begin
            state_q <= IDLE;
          end
        end
        MISS_REQ:  if (mem_ready_i) state_q <= MISS_WAIT;
        MISS_WAIT: if (mem_valid_i) state_q <= RESP;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // ---- stage p1: request metadata, response word and miss line address ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_p1         <= '0;
      act_mask_p1   <= '0;
      warp_id_p1    <= '0;
      subwarp_id_p1 <= '0;
      inst_p1       <= '0;
      mem_addr_p1   <= '0;
    end else if (accept) begin
      pc_p1         <= fe_pc_i;
      act_mask_p1   <= fe_act_mask_i;
      warp_id_p1    <= fe_warp_id_i;
      subwarp_id_p1 <= fe_subwarp_id_i;
      if (lookup_hit) begin
        inst_p1 <= lookup_word;
      end else begin
        mem_addr_p1 <= fe_pc_i[PcWidth-1:CachelineIdxBits];
      end
    end else if (fill_en) begin
      inst_p1 <= fill_word;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios plus a random run.
module tb_instr_cache;

  logic         clk = 1'b0;
  logic         rst_i, flush_i, mem_ready_i, mem_req_o, mem_valid_i;
  logic [6:0]   mem_addr_o;
  logic [127:0] mem_data_i;
  logic         ic_ready_o, fe_valid_i, dec_ready_i, ic_valid_o;
  logic [8:0]   fe_pc_i, ic_pc_o;
  logic [3:0]   fe_act_mask_i, ic_act_mask_o, fe_warp_id_i, ic_warp_id_o;
  logic [1:0]   fe_subwarp_id_i, ic_subwarp_id_o;
  logic [31:0]  ic_inst_o;

  always #5 clk = ~clk;

  instr_cache dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .ic_ready_o(ic_ready_o), .fe_valid_i(fe_valid_i), .fe_pc_i(fe_pc_i),
    .fe_act_mask_i(fe_act_mask_i), .fe_warp_id_i(fe_warp_id_i),
    .fe_subwarp_id_i(fe_subwarp_id_i), .dec_ready_i(dec_ready_i),
    .ic_valid_o(ic_valid_o), .ic_pc_o(ic_pc_o), .ic_act_mask_o(ic_act_mask_o),
    .ic_warp_id_o(ic_warp_id_o), .ic_subwarp_id_o(ic_subwarp_id_o),
    .ic_inst_o(ic_inst_o)
  );

  typedef struct packed {
    logic [8:0]  pc;
    logic [3:0]  mask;
    logic [3:0]  wid;
    logic [1:0]  sub;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   req_cnt = 0;
  logic [6:0] last_addr = '0;
  int   fixed_lat = 1;
  bit   mem_hold = 0, rnd_mode = 0, cons_rnd = 0, rnd_flush = 0;
  int   bp_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction memory contents: a distinct word for every PC.
  function automatic logic [31:0] mem_word(input logic [8:0] pc);
    return {pc, 7'h35, ~pc, 7'h00};
  endfunction

  function automatic logic [127:0] mem_line(input logic [6:0] addr);
    logic [127:0] l;
    for (int j = 0; j < 4; j++) l[j*32 +: 32] = mem_word({addr, 2'(j)});
    return l;
  endfunction

  // Memory responder: accepts requests, returns the line after a latency.
  initial begin
    int wait_cnt = 0;
    logic [6:0] pend = '0;
    mem_ready_i = 0; mem_valid_i = 0; mem_data_i = '0;
    forever begin
      @(negedge clk);
      mem_valid_i = 0;
      mem_ready_i = 0;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          mem_valid_i = 1;
          mem_data_i  = mem_line(pend);
        end
      end else if (mem_req_o && !mem_hold && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
        mem_ready_i = 1;
        pend        = mem_addr_o;
        last_addr   = mem_addr_o;
        req_cnt++;
        wait_cnt    = rnd_mode ? int'($urandom_range(1, 4)) : fixed_lat;
      end
    end
  end

  // Decoder side: drives dec_ready_i and scores every handshaked response.
  initial begin
    logic [50:0] snap = '0;
    bit snap_ok = 0;
    exp_t e;
    dec_ready_i = 1;
    forever begin
      @(negedge clk);
      if (ic_valid_o && bp_cnt > 0) begin
        dec_ready_i = 0;
        if (!snap_ok) begin
          snap = {ic_pc_o, ic_act_mask_o, ic_warp_id_o, ic_subwarp_id_o, ic_inst_o};
          snap_ok = 1;
        end else begin
          check("bp_hold", {ic_valid_o, ic_pc_o, ic_act_mask_o, ic_warp_id_o, ic_subwarp_id_o, ic_inst_o},
                {1'b1, snap});
        end
        bp_cnt--;
        #1 check("bp_ready", ic_ready_o, 0);
      end else begin
        snap_ok = 0;
        dec_ready_i = cons_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (ic_valid_o && dec_ready_i) begin
          if (exp_q.size() == 0) begin
            check("resp_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("resp_inst", ic_inst_o, e.inst);
            check("resp_meta", {ic_pc_o, ic_act_mask_o, ic_warp_id_o, ic_subwarp_id_o},
                  {e.pc, e.mask, e.wid, e.sub});
          end
        end
      end
    end
  end

  // Present one request starting at a negedge; returns at the negedge after acceptance.
  task automatic fetch(input logic [8:0] pc, input logic [3:0] mask, input logic [3:0] wid,
                       input logic [1:0] sub, output int waited);
    exp_t e;
    waited = 0;
    fe_pc_i = pc; fe_act_mask_i = mask; fe_warp_id_i = wid; fe_subwarp_id_i = sub;
    fe_valid_i = 1;
    forever begin
      if (rnd_flush) flush_i = ($urandom_range(0, 63) == 0);
      #1;
      if (ic_ready_o) break;
      @(negedge clk);
      waited++;
      if (waited > 1000) begin
        check("fetch_timeout", 1, 0);
        fe_valid_i = 0;
        return;
      end
    end
    e.pc = pc; e.mask = mask; e.wid = wid; e.sub = sub; e.inst = mem_word(pc);
    exp_q.push_back(e);
    @(negedge clk);
    fe_valid_i = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_req(input int snap_cnt);
    int n = 0;
    #1;
    while (req_cnt == snap_cnt && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("req_seen", req_cnt, snap_cnt + 1);
  endtask

  initial begin
    int w, snap_cnt;
    logic [8:0] pc;
    rst_i = 1; flush_i = 0; fe_valid_i = 0;
    fe_pc_i = '0; fe_act_mask_i = '0; fe_warp_id_i = '0; fe_subwarp_id_i = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", ic_valid_o, 0);
    check("rst_memreq", mem_req_o, 0);
    check("rst_memaddr", mem_addr_o, 0);
    check("rst_data", {ic_pc_o, ic_act_mask_o, ic_warp_id_o, ic_subwarp_id_o, ic_inst_o}, 0);
    rst_i = 0;
    @(negedge clk);
    #1 check("rst_ready", ic_ready_o, 1);
    @(negedge clk);

    // Cold miss
    snap_cnt = req_cnt;
    fetch(9'h014, 4'b1011, 4'd3, 2'd1, w);
    wait_drain();
    check("cold_req", req_cnt, snap_cnt + 1);
    check("cold_addr", last_addr, 7'h05);

    // Back-to-back hits
    snap_cnt = req_cnt;
    fetch(9'h015, 4'b0110, 4'd7, 2'd2, w);
    check("hit1_lat", {ic_valid_o, ic_pc_o, ic_inst_o}, {1'b1, 9'h015, mem_word(9'h015)});
    fetch(9'h017, 4'b1111, 4'd9, 2'd3, w);
    check("hit2_b2b", w, 0);
    check("hit2_lat", {ic_valid_o, ic_pc_o, ic_inst_o}, {1'b1, 9'h017, mem_word(9'h017)});
    wait_drain();
    check("hit_nomem", req_cnt, snap_cnt);

    // Conflict miss and replacement
    snap_cnt = req_cnt;
    fetch(9'h054, 4'b0001, 4'd1, 2'd0, w);
    wait_drain();
    check("conf_addr", last_addr, 7'h15);
    fetch(9'h014, 4'b0010, 4'd2, 2'd1, w);
    wait_drain();
    check("conf_addr2", last_addr, 7'h05);
    check("conf_req", req_cnt, snap_cnt + 2);

    // Flush across MISS_WAIT, including the fill cycle
    fixed_lat = 3;
    snap_cnt = req_cnt;
    fetch(9'h020, 4'b1100, 4'd5, 2'd2, w);
    wait_req(snap_cnt);
    @(negedge clk);
    flush_i = 1;
    repeat (3) @(negedge clk);
    flush_i = 0;
    wait_drain();
    check("flush_addr", last_addr, 7'h08);
    fixed_lat = 1;
    fetch(9'h021, 4'b1010, 4'd6, 2'd3, w);
    wait_drain();
    check("flush_miss", req_cnt, snap_cnt + 2);
    check("flush_addr2", last_addr, 7'h08);
    fetch(9'h014, 4'b0101, 4'd4, 2'd0, w);
    wait_drain();
    check("flush_miss2", req_cnt, snap_cnt + 3);

    // Decoder backpressure on a hit
    snap_cnt = req_cnt;
    bp_cnt = 5;
    fetch(9'h016, 4'b0111, 4'd11, 2'd1, w);
    wait_drain();
    check("bp_nomem", req_cnt, snap_cnt);

    // Memory backpressure in MISS_REQ
    mem_hold = 1;
    fetch(9'h100, 4'b1001, 4'd12, 2'd2, w);
    for (int i = 0; i < 5; i++) begin
      check("memhold", {mem_req_o, mem_addr_o}, {1'b1, 7'h40});
      @(negedge clk);
    end
    mem_hold = 0;
    wait_drain();

    // Reset in the middle of a miss; the late line must be ignored
    fixed_lat = 3;
    snap_cnt = req_cnt;
    fetch(9'h0C0, 4'b0011, 4'd13, 2'd3, w);
    wait_req(snap_cnt);
    @(negedge clk);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_abandon", {ic_valid_o, mem_req_o}, 0);
    end
    fixed_lat = 1;
    snap_cnt = req_cnt;
    fetch(9'h016, 4'b1110, 4'd14, 2'd0, w);
    wait_drain();
    check("rst_invalid", req_cnt, snap_cnt + 1);

    // Random traffic with flushes and stalls on both sides
    rnd_mode = 1; cons_rnd = 1; rnd_flush = 1;
    for (int i = 0; i < 1000; i++) begin
      pc = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 63));
      fetch(pc, 4'($urandom), 4'($urandom), 2'($urandom), w);
      flush_i = 0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    rnd_flush = 0; flush_i = 0;
    wait_drain();
    rnd_mode = 0; cons_rnd = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
Direct-mapped, blocking instruction cache between the warp fetcher and the decoder of the GPU core. It accepts one fetch request at a time (PC plus warp metadata) and looks it up in a tag/data array. On a miss it requests the whole cacheline from instruction memory and fills the line. It returns the encoded instruction with the unchanged metadata, strictly in request order.

Parameters:
PcWidth, 9, instruction-word address width (one PC step = one instruction)
NumWarps, 16, number of warps; WidWidth = max(1, clog2(NumWarps))
WarpWidth, 4, threads per warp; act_mask width; SubwarpIdWidth = max(1, clog2(WarpWidth))
EncInstWidth, 32, width of an encoded instruction
CachelineIdxBits, 2, log2 of instructions per line; LineWords = 2**CachelineIdxBits
NumCachelines, 16, number of lines (power of two); IdxBits = clog2(NumCachelines); TagBits = PcWidth-CachelineIdxBits-IdxBits, which must be at least 1

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset, synchronous, active-high
flush_i  in  1  invalidate all cachelines
mem_ready_i  in  1  memory accepts request
mem_req_o  out  1  memory request valid
mem_addr_o  out  PcWidth-CachelineIdxBits  line address = pc[PcWidth-1:CachelineIdxBits]
mem_valid_i  in  1  line data valid; no ready, must be consumed
mem_data_i  in  EncInstWidth*LineWords  word j = instruction at line_addr*LineWords+j
ic_ready_o  out  1  cache accepts fetch request
fe_valid_i  in  1  fetch request valid
fe_pc_i  in  PcWidth  instruction PC
fe_act_mask_i  in  WarpWidth  active thread mask
fe_warp_id_i  in  WidWidth  warp id
fe_subwarp_id_i  in  SubwarpIdWidth  subwarp id
dec_ready_i  in  1  decoder accepts response
ic_valid_o  out  1  response valid
ic_pc_o, ic_act_mask_o, ic_warp_id_o, ic_subwarp_id_o  out  as inputs  echoed request metadata
ic_inst_o  out  EncInstWidth  instruction word at ic_pc_o

Behaviour:
- Storage: valid bit, tag and LineWords words per line. Index = pc[CachelineIdxBits+IdxBits-1:CachelineIdxBits]. Word offset = pc[CachelineIdxBits-1:0]. Tag = upper PC bits.
- Single request stage with states IDLE, RESP, MISS_REQ, MISS_WAIT. All outputs are registered or decoded from the state.
- ic_ready_o = (state==IDLE) || (state==RESP && dec_ready_i).
- Accept (fe_valid_i && ic_ready_o):
  - Latch the metadata.
  - Look up fe_pc_i combinationally against the array contents before this edge.
  - Hit: latch the word and go to RESP (response 1 cycle after accept).
  - Miss: go to MISS_REQ.
- RESP: ic_valid_o=1.
  - On dec_ready_i, go to IDLE, or straight into the next accepted request (back-to-back hits give 1 response per cycle).
  - Outputs hold stable until handshake.
- MISS_REQ: mem_req_o=1 with a stable mem_addr_o. On mem_ready_i go to MISS_WAIT.
- MISS_WAIT: mem_valid_i is ignored in every other state.
  - On mem_valid_i, write data and tag to the indexed line and set its valid bit.
  - Latch the requested word into the stage and go to RESP.
- At most one outstanding memory request. Responses are in exact acceptance order, with metadata unchanged.
- flush_i clears all valid bits at the next edge.
  - A pending stage is not cancelled: it completes with the fetched or latched word.
  - If a fill and a flush happen in the same cycle, data and tag are written but the flush clears the valid bit.
  - A lookup in the flush cycle uses the pre-flush contents.
- Reset: state IDLE, all valid bits 0. Outputs: ic_valid_o=0, mem_req_o=0, mem_addr_o=0, ic_* data=0. ic_ready_o=1 from the first cycle after reset.
  - Reset mid-miss abandons the request; a later stray mem_valid_i is ignored (state IDLE).
- ic_ready_o and ic_valid_o never depend combinationally on fe_valid_i. ic_ready_o may depend on dec_ready_i.

Decomposition:
- Shared package (bgpu_pkg) holds the width helpers and the typedefs pc_t, act_mask_t, wid_t, subwarp_id_t, enc_inst_t, and cache_addr_t = PcWidth-CachelineIdxBits bits.
- One natural sub-module: instr_cache_tag_array, holding the valid/tag/data storage with lookup, fill and flush ports. The stage FSM lives in the top.

Test Plan:
- Cold miss, pc=0x014, mask=4'b1011, wid=3, subwarp=1 -> mem_req_o with mem_addr_o=0x05; respond with words {W3,W2,W1,W0}. Required: ic_valid_o with ic_inst_o=W0, metadata echoed.
- Follow-up hits pc=0x015, then 0x017 with dec_ready_i=1 -> no mem_req_o; ic_inst_o=W1, then W3. Accept in consecutive cycles, responses 1 cycle after each accept.
- Conflict: pc=0x054 (same index 5, tag differs) -> miss, mem_addr_o=0x15, line replaced. A new pc=0x014 then misses again with mem_addr_o=0x05.
- Flush asserted during MISS_WAIT for pc=0x020 -> response still delivered with the correct word. A subsequent pc=0x021 misses (mem_addr_o=0x08).
- Backpressure: dec_ready_i=0 for 5 cycles in RESP -> ic_valid_o and all outputs stable, ic_ready_o=0, mem_ready_i=0 in MISS_REQ holds mem_req_o and mem_addr_o stable.
- Random: 1000 requests with random PCs, random flush (~1/64), random stalls -> every response matches memory[pc] and the metadata, in order, with no watchdog stall beyond 1000 cycles.
